// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: two-flop pad synchronizer, per-bit tick-based debounce
// with bypass/output-direction pass-through, and registered-level edge pulses.
module gpio_in_conditioner #(
    parameter int WIDTH        = 21,
    parameter int TICK_DIV     = 5000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bypass_i,
    input  logic [WIDTH-1:0] gpio_pad_i,
    input  logic [WIDTH-1:0] gpio_dir_i,
    output logic [WIDTH-1:0] gpio_in_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] r_sync_1;
    logic [WIDTH-1:0] r_sync_q;
    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_prev_q;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [PW-1:0]    r_presc;

    logic             w_tick;
    logic [WIDTH-1:0] w_pass;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_pass = {WIDTH{bypass_i}} | gpio_dir_i;

    // Plain flop pair, nothing in between, so the tool can treat it as a synchronizer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_1 <= '0;
            r_sync_q <= '0;
        end else begin
            r_sync_1 <= gpio_pad_i;
            r_sync_q <= r_sync_1;
        end
    end

    // Free-running sample prescaler, independent of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // NOTE: the counter array is reset explicitly; a pending change must not survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q  <= '0;
            r_prev_q <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_prev_q <= r_out_q;
            for (int b = 0; b < WIDTH; b++) begin
                if (w_pass[b]) begin
                    r_out_q[b] <= r_sync_q[b];
                    r_cnt[b]   <= '0;
                end else if (w_tick) begin
                    if (r_sync_q[b] == r_out_q[b]) begin
                        r_cnt[b] <= '0;
                    end else if (r_cnt[b] == CNT_LAST) begin
                        r_out_q[b] <= r_sync_q[b];
                        r_cnt[b]   <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + CW'(1);
                    end
                end
            end
        end
    end

    assign gpio_in_o = r_out_q;
    assign rise_o    = r_out_q & ~r_prev_q;
    assign fall_o    = ~r_out_q & r_prev_q;

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 21, number of GPIO pad bits conditioned.
REQ-002 Parameter TICK_DIV, default 5000, clk cycles per debounce sample tick; legal range >= 2.
REQ-003 Parameter STABLE_TICKS, default 4, consecutive differing samples required to accept a change; legal range >= 1.
REQ-004 clk  input  1  SoC clock, same clock as the core consuming gpio_in.
REQ-005 rst_n  input  1  reset; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 bypass_i  input  1  1 = debounce disabled, synchronized pad value passed through.
REQ-007 gpio_pad_i  input  WIDTH  raw asynchronous pad levels.
REQ-008 gpio_dir_i  input  WIDTH  per-bit direction from the GPIO peripheral; 1 = output.
REQ-009 gpio_in_o  output  WIDTH  conditioned level, fed to the core gpio_in port.
REQ-010 rise_o  output  WIDTH  one-cycle pulse per bit on a 0->1 change of gpio_in_o.
REQ-011 fall_o  output  WIDTH  one-cycle pulse per bit on a 1->0 change of gpio_in_o.

Function
REQ-012 Each pad bit SHALL pass through a two-flop synchronizer (sync_q); no logic between the two flops.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, asserting an internal tick for exactly one cycle when the count equals TICK_DIV-1.
REQ-014 The prescaler SHALL run continuously regardless of bypass_i and gpio_dir_i.
REQ-015 Each bit SHALL hold a registered output state out_q (driving gpio_in_o) and a stable counter cnt of width clog2(STABLE_TICKS+1).
REQ-016 Debounce mode (bypass_i=0, gpio_dir_i[b]=0), on tick: sync_q==out_q -> cnt<=0; else cnt==STABLE_TICKS-1 -> out_q<=sync_q, cnt<=0; else cnt<=cnt+1.
REQ-017 Debounce mode, no tick: out_q and cnt SHALL hold.
REQ-018 A single tick sampling sync_q==out_q SHALL clear cnt, so glitches shorter than STABLE_TICKS ticks never reach gpio_in_o.
REQ-019 Pass mode (bypass_i=1 or gpio_dir_i[b]=1): out_q<=sync_q every cycle, cnt<=0.
REQ-020 Pad-to-gpio_in_o latency in pass mode SHALL be 3 clk rising edges.
REQ-021 Switching a bit from pass mode to debounce mode SHALL start from cnt=0 and the current out_q, with no output glitch.
REQ-022 Switching from debounce mode to pass mode SHALL update out_q on the next edge even if cnt is mid-count.
REQ-023 Edge detection: prev_q<=out_q every cycle; rise_o=out_q & ~prev_q, fall_o=~out_q & prev_q, asserted in the same cycle gpio_in_o changes.
REQ-024 Bits SHALL be independent; simultaneous changes on several bits produce simultaneous pulses.

Reset
REQ-025 While rst_n=0: sync flops, out_q, prev_q, cnt and prescaler SHALL all be 0, so gpio_in_o, rise_o and fall_o are 0.
REQ-026 Reset deassertion SHALL produce no rise_o/fall_o pulse for pads held at 0; a pad held at 1 yields a single rise_o once accepted.
REQ-027 Reset asserted mid-count SHALL discard the pending change; counting restarts from 0 after release.

Verification (bench uses TICK_DIV=4, STABLE_TICKS=3, WIDTH=21)
REQ-028 Bypass: bypass_i=1, pad[0] 0->1 at edge N -> gpio_in_o[0]=1 and rise_o[0]=1 for one cycle after edge N+3.
REQ-029 Debounce accept: bypass_i=0, pad[5] 0->1 held 20 cycles -> gpio_in_o[5] rises after the 3rd tick following synchronization (9-16 cycles); exactly one rise_o[5] pulse.
REQ-030 Glitch reject: pad[5] high for 6 cycles then low -> gpio_in_o[5] stays 0, no pulses, cnt returns to 0.
REQ-031 Direction readback: gpio_dir_i[7]=1, bypass_i=0, pad[7] toggles every 4 cycles -> gpio_in_o[7] follows with 3-cycle latency; rise_o/fall_o pulse on every toggle.
REQ-032 Reset mid-count: pad[2]=1 for 2 ticks, rst_n pulsed low 1 cycle -> all outputs 0 during reset; gpio_in_o[2] rises only after 3 further ticks.
REQ-033 Multi-bit: pad[20:0] 0 -> 0x1FFFFF at once, debounced -> all 21 gpio_in_o bits and rise_o bits assert in the same cycle.
